rr_arbiter_timeslice: RTL and testbench



---
 rtl/arb_pkg.sv | 27 ++
 rtl/rr_arbiter_timeslice_pick.sv | 47 ++++
 rtl/rr_arbiter_timeslice.sv | 131 +++++++++++++
 tb/tb_rr_arbiter_timeslice.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the time-sliced round-robin arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable; nothing in this file holds state.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Widest requester vector the helper accepts (NUM_REQ legal up to 32).
    localparam int MAX_REQ = 32;

    // Binary index of a one-hot vector. The indices of all set bits are
    // ORed together, so the result is only meaningful for one-hot input.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_timeslice_pick.sv
// Rotate-priority picker: first set request after ptr, wrapping, ending at ptr.
// Latency: purely combinational.
// Backpressure: none; found/pick follow req, ptr and excl_ptr directly.
//
// Ports:
//   req      requester vector, bit i = requester i
//   ptr      rotation pointer; the search starts at ptr+1 (mod NUM_REQ)
//   excl_ptr when high, requester ptr is never picked
//   found    high when any eligible request exists
//   pick     one-hot selected requester (zero when found is low)
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               excl_ptr,
    output logic               found,
    output logic [NUM_REQ-1:0] pick
);

    localparam int             DW       = 2 * NUM_REQ;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] excl_mask;
    logic [NUM_REQ-1:0] req_m;
    logic [IDX_W-1:0]   start;
    logic [DW-1:0]      dbl;
    logic [DW-1:0]      dbl_m;
    logic [DW-1:0]      dbl_low;

    assign excl_mask = excl_ptr ? (NUM_REQ'(1) << ptr) : '0;
    assign req_m     = req & ~excl_mask;

    // Explicit wrap keeps non-power-of-two NUM_REQ correct.
    assign start = (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);

    // Lower copy covers start..NUM_REQ-1; the unmasked upper copy supplies
    // the wrapped part 0..ptr. Lowest surviving bit is the winner.
    assign dbl     = {req_m, req_m};
    assign dbl_m   = dbl & ({DW{1'b1}} << start);
    assign dbl_low = dbl_m & (~dbl_m + DW'(1));

    assign pick  = dbl_low[NUM_REQ-1:0] | dbl_low[DW-1:NUM_REQ];
    assign found = |req_m;

endmodule

// File: rtl/rr_arbiter_timeslice.sv
// Round-robin arbiter that holds each grant for at most SLICE_CYCLES cycles.
// Latency: one cycle from req to registered gnt; no combinational req->gnt path.
// Backpressure: none; owners drop req to release early, gnt lags by one cycle.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   req        request vector, bit i = requester i
//   gnt        registered one-hot grant, zero when idle
//   gnt_valid  high when any gnt bit is set
//   gnt_idx    binary index of the owner, zero when idle
//   slice_last high in the final cycle of the owner's slice
module rr_arbiter_timeslice
    import arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int SLICE_CYCLES = 4,
    localparam int IDX_W        = $clog2(NUM_REQ),
    localparam int CNT_W        = $clog2(SLICE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               slice_last
);

    localparam logic [CNT_W-1:0] SLICE_MAX = CNT_W'(SLICE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;      // current owner while in GRANT
    logic [IDX_W-1:0]   last_q, last_d;    // most recent owner, survives IDLE
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               slice_last_q, slice_last_d;

    logic [IDX_W-1:0]   pick_ptr;
    logic               pick_excl;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;

    // One picker serves both states: from IDLE search after last owner with
    // everyone eligible; in GRANT search after the owner, excluding it, which
    // covers both the early-release and the slice-expiry hand-over.
    assign pick_ptr  = (state_q == GRANT) ? idx_q : last_q;
    assign pick_excl = (state_q == GRANT);

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .excl_ptr (pick_excl),
        .found    (pick_found),
        .pick     (pick_oh)
    );

    assign pick_idx  = IDX_W'(onehot_to_idx(MAX_REQ'(pick_oh)));
    assign owner_req = req[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                idx_d   = pick_idx;
                cnt_d   = CNT_W'(1);
            end
        end else begin
            if (!owner_req) begin
                if (pick_found) begin
                    // Hand straight over; no idle cycle between owners.
                    idx_d = pick_idx;
                    cnt_d = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end else if (cnt_q == SLICE_MAX) begin
                // Slice spent: rotate if anyone else waits, else renew.
                cnt_d = CNT_W'(1);
                if (pick_found) begin
                    idx_d = pick_idx;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_d == GRANT) begin
            last_d = idx_d;
        end

        gnt_d        = (state_d == GRANT) ? (NUM_REQ'(1) << idx_d) : '0;
        slice_last_d = (state_d == GRANT) && (cnt_d == SLICE_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= LAST_IDX;
            cnt_q        <= '0;
            gnt_q        <= '0;
            slice_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            slice_last_q <= slice_last_d;
        end
    end

    assign gnt        = gnt_q;
    assign gnt_valid  = (state_q == GRANT);
    assign gnt_idx    = idx_q;
    assign slice_last = slice_last_q;

endmodule

// File: tb/tb_rr_arbiter_timeslice.sv
// Bench for rr_arbiter_timeslice: 4-way/slice-4 and 8-way/slice-1 instances.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_rr_arbiter_timeslice;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req4  = '0;
    logic [7:0] req8  = '0;

    logic [3:0] gnt4;
    logic       vld4;
    logic [1:0] idx4;
    logic       last4;
    logic [7:0] gnt8;
    logic       vld8;
    logic [2:0] idx8;
    logic       last8;

    always #5 clk = ~clk;

    rr_arbiter_timeslice #(.NUM_REQ(4), .SLICE_CYCLES(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .req        (req4),
        .gnt        (gnt4),
        .gnt_valid  (vld4),
        .gnt_idx    (idx4),
        .slice_last (last4)
    );

    rr_arbiter_timeslice #(.NUM_REQ(8), .SLICE_CYCLES(1)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .req        (req8),
        .gnt        (gnt8),
        .gnt_valid  (vld8),
        .gnt_idx    (idx8),
        .slice_last (last8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Owner -1 means idle. Search order follows the rule "start after p,
    // wrap, finish with p", walked one offset at a time.
    typedef struct {
        int owner;
        int cnt;
        int last;
    } mdl_t;

    function automatic int next_pending(int p, logic [31:0] r, int n, bit excl);
        for (int k = 1; k <= n; k++) begin
            int i;
            i = (p + k) % n;
            if (r[i] && !(excl && i == p)) return i;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [31:0] r, int n, int s);
        mdl_t x;
        int   c;
        x = m;
        if (x.owner < 0) begin
            c = next_pending(x.last, r, n, 1'b0);
            if (c >= 0) begin
                x.owner = c;
                x.cnt   = 1;
            end
        end else if (!r[x.owner]) begin
            c = next_pending(x.owner, r, n, 1'b1);
            if (c >= 0) begin
                x.owner = c;
                x.cnt   = 1;
            end else begin
                x.last  = x.owner;
                x.owner = -1;
                x.cnt   = 0;
            end
        end else if (x.cnt == s) begin
            c = next_pending(x.owner, r, n, 1'b1);
            if (c >= 0) x.owner = c;
            x.cnt = 1;
        end else begin
            x.cnt = x.cnt + 1;
        end
        if (x.owner >= 0) x.last = x.owner;
        return x;
    endfunction

    function automatic logic [31:0] mdl_gnt(mdl_t m);
        return (m.owner < 0) ? 32'd0 : (32'd1 << m.owner);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       last;
    } vec_t;

    vec_t tbl[18];

    mdl_t m4, m8;
    int   w4[4];
    int   w8[8];
    int   worst;
    logic [3:0] r4;
    logic [7:0] r8;
    int   exp8[6];

    initial begin
        // Early release, idle fairness and lone-requester slice reload.
        tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[12] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[13] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[16] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[17] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        exp8[0] = 0; exp8[1] = 2; exp8[2] = 5; exp8[3] = 7; exp8[4] = 0; exp8[5] = 2;

        // Reset state, checked while reset is still asserted.
        #12;
        chk("rst_gnt4",  32'(gnt4),  32'd0);
        chk("rst_vld4",  32'(vld4),  32'd0);
        chk("rst_idx4",  32'(idx4),  32'd0);
        chk("rst_last4", 32'(last4), 32'd0);
        chk("rst_gnt8",  32'(gnt8),  32'd0);
        chk("rst_vld8",  32'(vld8),  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            req4 = tbl[i].req;
            step();
            chk($sformatf("tbl%0d_gnt", i),  32'(gnt4),  32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_idx", i),  32'(idx4),  32'(tbl[i].idx));
            chk($sformatf("tbl%0d_vld", i),  32'(vld4),  32'(tbl[i].vld));
            chk($sformatf("tbl%0d_last", i), 32'(last4), 32'(tbl[i].last));
        end

        // Full contention: four cycles per owner, rotating on slice_last.
        pulse_reset();
        req4 = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("rot%0d_gnt", k),  32'(gnt4),  32'd1 << ((k / 4) % 4));
            chk($sformatf("rot%0d_idx", k),  32'(idx4),  32'((k / 4) % 4));
            chk($sformatf("rot%0d_last", k), 32'(last4), 32'((k % 4) == 3));
        end

        // Asynchronous reset mid-slice: outputs clear between clock edges.
        step();
        chk("pre_arst_vld", 32'(vld4), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_gnt4", 32'(gnt4), 32'd0);
        chk("arst_vld4", 32'(vld4), 32'd0);
        chk("arst_last4", 32'(last4), 32'd0);
        #1;
        reset = 1'b0;
        step();
        chk("post_arst_gnt4", 32'(gnt4), 32'd1);
        chk("post_arst_idx4", 32'(idx4), 32'd0);

        // 8-way, slice 1: per-cycle rotation over 8'hA5.
        req4 = 4'b0000;
        pulse_reset();
        req8 = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("a5_%0d_gnt", k),  32'(gnt8),  32'd1 << exp8[k]);
            chk($sformatf("a5_%0d_last", k), 32'(last8), 32'd1);
        end

        // Random run on both instances against the model.
        pulse_reset();
        m4 = '{-1, 0, 3};
        m8 = '{-1, 0, 7};
        foreach (w4[i]) w4[i] = 0;
        foreach (w8[i]) w8[i] = 0;
        r4 = '0;
        r8 = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r4 = r4 ^ 4'($urandom & $urandom);
            r8 = r8 ^ 8'($urandom & $urandom);
            if ($urandom_range(0, 31) == 0) r4 = '0;
            if ($urandom_range(0, 31) == 0) r8 = '0;
            req4 = r4;
            req8 = r8;
            step();
            m4 = mdl_step(m4, 32'(r4), 4, 4);
            m8 = mdl_step(m8, 32'(r8), 8, 1);

            chk("rnd4_gnt",  32'(gnt4),  mdl_gnt(m4));
            chk("rnd4_idx",  32'(idx4),  (m4.owner < 0) ? 32'd0 : 32'(m4.owner));
            chk("rnd4_last", 32'(last4), 32'(m4.owner >= 0 && m4.cnt == 4));
            chk("rnd8_gnt",  32'(gnt8),  mdl_gnt(m8));
            chk("rnd8_idx",  32'(idx8),  (m8.owner < 0) ? 32'd0 : 32'(m8.owner));
            chk("rnd8_last", 32'(last8), 32'(m8.owner >= 0));
            chk("rnd4_onehot0", 32'((gnt4 & (gnt4 - 4'd1)) == 4'd0), 32'd1);
            chk("rnd8_onehot0", 32'((gnt8 & (gnt8 - 8'd1)) == 8'd0), 32'd1);
            chk("rnd4_vld", 32'(vld4), 32'(gnt4 != 4'd0));
            chk("rnd8_vld", 32'(vld8), 32'(gnt8 != 8'd0));

            // Edges a continuously asserted request has gone ungranted.
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (!r4[i] || gnt4[i]) w4[i] = 0;
                else                   w4[i] = w4[i] + 1;
                if (w4[i] > worst) worst = w4[i];
            end
            chk("starve4", 32'(worst <= 12), 32'd1);
            worst = 0;
            for (int i = 0; i < 8; i++) begin
                if (!r8[i] || gnt8[i]) w8[i] = 0;
                else                   w8[i] = w8[i] + 1;
                if (w8[i] > worst) worst = w8[i];
            end
            chk("starve8", 32'(worst <= 7), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
